// File: rtl/gmii_arb_pkg.sv
// Shared types and constants for the two-source GMII transmit arbiter.
// The GMII_ARB_WATCHDOG_EN build option adds the grant/frame watchdog in gmii_tx_arbiter.
package gmii_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SEND  = 2'd2,
        IFG   = 2'd3
    } arb_state_e;

    localparam int IFG_DEFAULT         = 12;
    localparam int GNT_TIMEOUT_DEFAULT = 256;
    localparam int MAX_FRAME_DEFAULT   = 1530;

    // Watchdog counter width; must hold MAX_FRAME and GNT_TIMEOUT-1.
    localparam int WD_W = 12;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

endpackage

// File: rtl/gmii_arb_rr_pick.sv
// Two-request round-robin picker: on a tie the source that is not ptr wins.
// Purely combinational; the pointer register lives in the parent.
module gmii_arb_rr_pick
    import gmii_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       gnt_idx,
    output logic       valid
);

    always_comb begin
        valid   = |req;
        gnt_idx = (req == 2'b11) ? ~ptr : req[1];
    end

endmodule

// File: rtl/gmii_tx_arbiter.sv
// Whole-frame round-robin arbiter for the shared GMII transmit path with IFG enforcement.
// Build option GMII_ARB_WATCHDOG_EN adds grant-timeout and max-frame aborts with err_pulse.
module gmii_tx_arbiter
    import gmii_arb_pkg::*;
#(
    parameter int IFG_CYCLES  = IFG_DEFAULT
`ifdef GMII_ARB_WATCHDOG_EN
    ,
    parameter int GNT_TIMEOUT = GNT_TIMEOUT_DEFAULT,
    parameter int MAX_FRAME   = MAX_FRAME_DEFAULT
`endif
) (
    input  logic       tx_clk,
    input  logic       rst_n,
    input  logic       s0_req,
    output logic       s0_gnt,
    input  logic       s0_tx_en,
    input  logic [7:0] s0_tx_data,
    input  logic       s1_req,
    output logic       s1_gnt,
    input  logic       s1_tx_en,
    input  logic [7:0] s1_tx_data,
    output logic       gmii_tx_en,
    output logic [7:0] gmii_tx_data,
    output logic       busy,
    output logic       err_pulse
);

    localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    arb_state_e       state_q, state_d;
    logic             sel_q, sel_d;
    logic             ptr_q, ptr_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [IFG_W-1:0] ifg_q, ifg_d;
    logic             fwd_en;
    logic [7:0]       tx_data_d;
    logic [1:0]       req_vec;
    logic             pick_idx, pick_valid;

    // Only the selected source is ever looked at; the other one is fully muted.
    wire       sel_req     = sel_q ? s1_req     : s0_req;
    wire       sel_tx_en   = sel_q ? s1_tx_en   : s0_tx_en;
    wire [7:0] sel_tx_data = sel_q ? s1_tx_data : s0_tx_data;

`ifdef GMII_ARB_WATCHDOG_EN
    logic [WD_W-1:0] wd_q, wd_d;
    logic [1:0]      blocked_q, blocked_d;
    logic            err_q, err_d;
    logic            abort;

    assign req_vec   = {s1_req, s0_req} & ~blocked_q;
    assign err_pulse = err_q;
`else
    assign req_vec   = {s1_req, s0_req};
    assign err_pulse = 1'b0;
`endif

    gmii_arb_rr_pick u_pick (
        .req     (req_vec),
        .ptr     (ptr_q),
        .gnt_idx (pick_idx),
        .valid   (pick_valid)
    );

    assign s0_gnt = gnt_q[0];
    assign s1_gnt = gnt_q[1];
    assign busy   = (state_q != IDLE);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        ifg_d   = ifg_q;
        fwd_en  = sel_tx_en && ((state_q == GRANT) || (state_q == SEND));
`ifdef GMII_ARB_WATCHDOG_EN
        wd_d      = wd_q;
        err_d     = 1'b0;
        abort     = 1'b0;
        blocked_d = blocked_q & {s1_req, s0_req};
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    ptr_d   = pick_idx;
                    gnt_d   = pick_idx ? 2'b10 : 2'b01;
`ifdef GMII_ARB_WATCHDOG_EN
                    wd_d    = '0;
`endif
                end
            end
            GRANT: begin
                if (!sel_req) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    fwd_en  = 1'b0;
                end else if (sel_tx_en) begin
                    state_d = SEND;
`ifdef GMII_ARB_WATCHDOG_EN
                    wd_d    = WD_W'(1);
                end else if (wd_q == WD_W'(GNT_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    abort   = 1'b1;
                end else begin
                    wd_d    = wd_q + 1'b1;
`endif
                end
            end
            SEND: begin
                if (!sel_tx_en) begin
                    state_d = IFG;
                    gnt_d   = '0;
                    ifg_d   = IFG_W'(IFG_CYCLES - 1);
`ifdef GMII_ARB_WATCHDOG_EN
                end else if (wd_q == WD_W'(MAX_FRAME)) begin
                    // Frame overran: cut the enable and still enforce the full gap.
                    state_d = IFG;
                    gnt_d   = '0;
                    ifg_d   = IFG_W'(IFG_CYCLES - 1);
                    fwd_en  = 1'b0;
                    abort   = 1'b1;
                end else begin
                    wd_d    = wd_q + 1'b1;
`endif
                end
            end
            IFG: begin
                if (ifg_q == '0) state_d = IDLE;
                else             ifg_d   = ifg_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
`ifdef GMII_ARB_WATCHDOG_EN
        if (abort) begin
            err_d              = 1'b1;
            blocked_d[sel_q]   = 1'b1;
        end
`endif
        tx_data_d = fwd_en ? sel_tx_data : 8'h00;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= 1'b0;
            ptr_q        <= 1'b1;
            gnt_q        <= '0;
            ifg_q        <= '0;
            gmii_tx_en   <= 1'b0;
            gmii_tx_data <= 8'h00;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            ifg_q        <= ifg_d;
            gmii_tx_en   <= fwd_en;
            gmii_tx_data <= tx_data_d;
        end
    end

`ifdef GMII_ARB_WATCHDOG_EN
    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q      <= '0;
            blocked_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            blocked_q <= blocked_d;
            err_q     <= err_d;
        end
    end
`endif

endmodule

// File: doc/gmii_tx_arbiter.md
Name: gmii_tx_arbiter

Overview:
- Two-source arbiter for the shared GMII transmit path (tx_en/tx_data byte stream at tx_clk).
- Each source (e.g. periodic UDP frame generator, ARP/response generator) requests the link and is granted whole frames, round-robin.
- Enforces the inter-frame gap and forwards the granted byte stream with a one-cycle registered latency.
- Sits between the frame generators and the GMII/RGMII output stage.

Parameters:
- IFG_CYCLES, 12, idle cycles forced on gmii_tx_en after every frame end (minimum 1).
- GNT_TIMEOUT, 256, cycles a granted source may take to raise tx_en (watchdog only).
- MAX_FRAME, 1530, maximum tx_en-high cycles per frame, including the preamble (watchdog only).

Ports:
- tx_clk  in  1  transmit clock, 125 MHz; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s0_req  in  1  source 0 requests a frame slot; level, held until the frame ends.
- s0_gnt  out  1  source 0 owns the link.
- s0_tx_en  in  1  source 0 frame-valid.
- s0_tx_data  in  8  source 0 byte.
- s1_req  in  1  source 1 request.
- s1_gnt  out  1  source 1 grant.
- s1_tx_en  in  1  source 1 frame-valid.
- s1_tx_data  in  8  source 1 byte.
- gmii_tx_en  out  1  forwarded frame-valid.
- gmii_tx_data  out  8  forwarded byte.
- busy  out  1  state is not IDLE.
- err_pulse  out  1  one-cycle pulse on a watchdog abort.

Behaviour:
- Reset (async): state=IDLE; every output is 0; rr pointer=1, so s0 wins the first tie.
- FSM states: IDLE, GRANT, SEND, IFG.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that source.
  - Both requesting: grant the source not equal to the pointer. The pointer is updated to the granted source.
  - Next state GRANT; the corresponding sN_gnt is registered high in that same transition.
- GRANT:
  - Selected sel_req low (cancelled) -> IDLE, gnt low, no IFG.
  - Selected sel_tx_en high -> SEND, and the byte is forwarded.
- SEND: sel_tx_en low -> IFG. gnt drops on that same clock edge; the IFG counter loads IFG_CYCLES-1.
- IFG: counter decrements; at 0 -> IDLE. Requests are not sampled during IFG.
- Forwarding, registered, 1 cycle:
  - gmii_tx_en <= sel_tx_en while in GRANT or SEND.
  - gmii_tx_data <= sel_tx_data when the forwarded enable is set, otherwise 8'h00.
- The ungranted source's tx_en/tx_data are ignored entirely; they never reach the output.
- Gap guarantee: the gap between two forwarded frames is at least IFG_CYCLES gmii_tx_en-low cycles, plus the arbitration cycle.
- Simultaneous events:
  - A request arriving while the other source is in SEND waits.
  - req dropping in the same cycle tx_en falls is treated as a normal end of frame.
- tx_en dropping mid-frame for one cycle is treated as frame end; sources must keep tx_en contiguous.
- Mid-operation reset clears all outputs immediately; gmii_tx_en is 0 on the first cycle of reset.

Optional Feature:
- Macro: GMII_ARB_WATCHDOG_EN.
- Defined:
  - A 12-bit cycle counter runs in GRANT and SEND.
  - In GRANT, reaching GNT_TIMEOUT without tx_en -> IDLE, gnt low, err_pulse=1.
  - In SEND, reaching MAX_FRAME cycles with tx_en still high forces gmii_tx_en=0 from the next cycle -> IFG, gnt low, err_pulse=1.
  - After an abort, the source's tx_en is ignored until it drops req and re-requests.
- Undefined: GRANT waits indefinitely, SEND is unbounded, err_pulse is tied to 0, and the counter is not instantiated.

Decomposition:
- Package gmii_arb_pkg holds:
  - the state encoding (IDLE=2'd0, GRANT=2'd1, SEND=2'd2, IFG=2'd3);
  - default constants IFG_DEFAULT=12, GNT_TIMEOUT_DEFAULT=256, MAX_FRAME_DEFAULT=1530;
  - the preamble byte constants 8'h55 and 8'hD5 used by the bench.
- One sub-module, gmii_arb_rr_pick: two-request round-robin picker (req[1:0], ptr -> gnt_idx, valid). Purely combinational; the pointer register stays in the parent.

Test Plan:
- Single source: s0_req held, s0 sends a 114-cycle frame (7x8'h55, 8'hD5, payload) -> gmii_tx_en high exactly 114 cycles, delayed 1 cycle from s0_tx_en. Bytes match; s1_gnt stays 0.
- Contention: s0_req and s1_req rise in the same cycle after reset -> s0 is served first. s1_gnt rises only after 12 gmii_tx_en-low cycles; a third back-to-back pair is served s0 then s1, alternating.
- Isolation: s1 drives tx_en=1, data=8'hAA while s0 is granted -> 8'hAA never appears on gmii_tx_data.
- Cancel: s1_req pulses 3 cycles with no tx_en -> back to IDLE with no IFG; s0_req asserted after that -> s0_gnt within 2 cycles.
- Async reset mid-SEND, byte 40 -> gmii_tx_en, gmii_tx_data, gnts and busy are 0 before the next edge. After release, the first request is granted normally.
- Watchdog (macro defined): granted source idles 256 cycles -> err_pulse=1 and gnt drops. A 2000-cycle tx_en burst -> gmii_tx_en low after 1530 cycles and err_pulse=1.
